logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT) among NREQ requesters in the 8-bit microprocessor datapath. It accepts one request at a time over a valid/ready handshake, latches the operands, computes the result in a registered execute cycle, and holds the tagged result on a response port until it is consumed. Fairness is strict round-robin over requesters that present valid in the same cycle.

## Interface
- NREQ, 4: number of requesters; 2..8.
- WIDTH, 8: operand/result width.
- IDW, $clog2(NREQ): requester-index width (derived, not overridable).

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  2*NREQ  opcode, slice i = [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 NOT a.
- req_a  input  WIDTH*NREQ  operand a, slice i = [WIDTH*i +: WIDTH].
- req_b  input  WIDTH*NREQ  operand b, same slicing; ignored for NOT.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of requester that owns the result.
- rsp_y  output  WIDTH  result.
- rsp_zero  output  1  high when rsp_y == 0.

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: search req_valid starting at round-robin pointer ptr, ascending, wrapping modulo NREQ; first set bit is winner w. req_ready[w]=1 combinationally, all other bits 0. A handshake (req_valid[w] & req_ready[w]) latches op, a, b, id=w; ptr <= (w+1) mod NREQ; next state EXEC. No valid inputs: stay IDLE, ptr unchanged.
- EXEC: rsp_y <= f(op, a, b); rsp_zero <= (f == 0); rsp_id <= id; rsp_valid <= 1; next state RESP. req_ready = 0.
- RESP: hold rsp_* stable. rsp_valid & rsp_ready: rsp_valid <= 0, next state IDLE. req_ready = 0.
- req_ready is 0 in every state except IDLE.
- Requesters hold valid and payload until ready. Dropping valid before the grant is legal; that request is not counted and ptr does not move.
- Bitwise ops only; no carry, no width growth. NOT ignores b.
- Wrap: winner NREQ-1 sets ptr to 0.

## Timing
- Reset (rst_n low, any state, any time): state IDLE, ptr 0, rsp_valid 0, rsp_id 0, rsp_y 0, rsp_zero 0, req_ready 0 while rst_n low. An in-flight operation is discarded, with no response. Release is synchronous to the next clk edge.
- Latency: request accepted at edge N → rsp_valid high after edge N+1 (one EXEC cycle).
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
- rsp_ready high on the first RESP cycle: result consumed at that edge, IDLE on the next cycle. A new grant is never issued in the same cycle as a response handshake.
- Back-pressure: rsp_ready low holds RESP indefinitely, with outputs stable and all req_ready 0.
- req_ready depends combinationally on req_valid and state. It has no combinational path from rsp_ready.

## Test plan
- Reset mid-EXEC: req0 AND a=8'hF0 b=8'h3C accepted, rst_n pulled low during EXEC → rsp_valid stays 0, all outputs 0, ptr 0; after release a req1 request is granted first (ptr=0, only req1 valid).
- Single op each: req2 with op 00/01/10/11, a=8'hA5, b=8'h0F → rsp_y 8'h05/8'hAF/8'hAA/8'h5A, rsp_id 2, rsp_zero 0, rsp_valid exactly 2 cycles after the accept edge.
- Zero flag: XOR a=b=8'h77 → rsp_y 8'h00, rsp_zero 1.
- Round-robin: all four req_valid held high continuously, rsp_ready tied 1 → grant order 0,1,2,3,0, one grant every 3 cycles, never two req_ready bits high.
- Back-pressure: rsp_ready low for 10 cycles after rsp_valid → rsp_y/rsp_id stable, req_ready all 0. Raising rsp_ready → rsp_valid drops next cycle and the next grant follows one cycle later.
- Wrap and skip: ptr=3, only req3 and req1 valid → req3 granted, then req1 (ptr wrapped to 0, searches 0→1).

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters.
// One request in flight: IDLE grants, EXEC computes, RESP holds the tagged result.
module logic_unit_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [2*NREQ-1:0]      req_op,
   input  logic [WIDTH*NREQ-1:0]  req_a,
   input  logic [WIDTH*NREQ-1:0]  req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_y,
   output logic                   rsp_zero
);

   localparam int SW = IDW + 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_nx;
   logic [IDW-1:0]   ptr, ptr_nx, win, id_q;
   logic [SW-1:0]    sum;
   logic             found, accept;
   logic [1:0]       op_sel, op_q;
   logic [WIDTH-1:0] a_sel, b_sel, a_q, b_q, f;

   // Scan from ptr upward, wrapping modulo NREQ; first valid requester wins.
   always_comb begin
      found  = 1'b0;
      win    = '0;
      sum    = '0;
      op_sel = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
         if (!found && req_valid[sum[IDW-1:0]]) begin
            found = 1'b1;
            win   = sum[IDW-1:0];
         end
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (found && win == IDW'(k)) begin
            op_sel = req_op[2*k +: 2];
            a_sel  = req_a[WIDTH*k +: WIDTH];
            b_sel  = req_b[WIDTH*k +: WIDTH];
         end
      end
   end

   assign ptr_nx    = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
   assign req_ready = (rst_n && state == IDLE && found) ? (NREQ'(1) << win) : '0;

   always_comb begin
      unique case (op_q)
         2'b00:   f = a_q & b_q;
         2'b01:   f = a_q | b_q;
         2'b10:   f = a_q ^ b_q;
         default: f = ~a_q;
      endcase
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               accept   = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_y     <= '0;
         rsp_zero  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q <= op_sel;
            a_q  <= a_sel;
            b_q  <= b_sel;
            id_q <= win;
            ptr  <= ptr_nx;
         end
         if (state == EXEC) begin
            rsp_y     <= f;
            rsp_zero  <= (f == '0);
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized
// traffic checked against a distance-based round-robin and bitwise-op reference.
module tb_logic_unit_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [2*NREQ-1:0]     req_op = '0;
   logic [WIDTH*NREQ-1:0] req_a = '0;
   logic [WIDTH*NREQ-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_y;
   logic                  rsp_zero;

   int n_checks = 0;
   int n_pass = 0;
   int model_ptr = 0;
   int cyc = 0;
   int multi_hot = 0;

   logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_zero(rsp_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if ($countones(req_ready) > 1) multi_hot++;

   // Winner = valid requester at the smallest forward distance from the pointer.
   function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
      int best = -1;
      int bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (v[i]) begin
            int d = (i - p + NREQ) % NREQ;
            if (d < bestd) begin bestd = d; best = i; end
         end
      end
      return best;
   endfunction

   function automatic logic [7:0] model_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[i] = 1'b1;
      req_op[2*i +: 2] = op;
      req_a[WIDTH*i +: WIDTH] = a;
      req_b[WIDTH*i +: WIDTH] = b;
   endtask

   // Waits (bounded) for a grant; returns granted index (-1 on timeout) and model expectation.
   task automatic do_grant(input bit hold, output int g, output int at_cyc, output int exp);
      g = -1;
      at_cyc = -1;
      exp = model_winner(req_valid, model_ptr);
      for (int c = 0; c < 20 && g < 0; c++) begin
         @(negedge clk); #1;
         if (req_ready != '0) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            at_cyc = cyc;
         end
      end
      @(posedge clk); #1;
      if (g >= 0 && !hold) req_valid[g] = 1'b0;
      if (exp >= 0) model_ptr = (exp + 1) % NREQ;
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = c; break; end
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int g, at, exp, lat;
      rst_n = 1'b0;
      req_valid = '1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
      n_checks++; if ({rsp_valid, rsp_id, rsp_y, rsp_zero} !== '0)
         $display("FAIL reset_outputs: got v=%b id=%0d y=%h z=%b want all 0", rsp_valid, rsp_id, rsp_y, rsp_zero);
      else n_pass++;
      req_valid = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      model_ptr = 0;
      for (int run = 0; run < 2; run++) begin
         set_req(run == 0 ? 0 : 2, 2'd0, 8'hF0, 8'h3C);
         do_grant(1'b0, g, at, exp);
         n_checks++; if (g !== exp) $display("FAIL reset_pre_grant: got %0d want %0d", g, exp); else n_pass++;
         req_valid = (run == 0) ? 4'b0010 : 4'b1010;
         rst_n = 1'b0;
         #1;
         model_ptr = 0;
         n_checks++; if ({rsp_valid, rsp_id, rsp_y, rsp_zero, req_ready} !== '0)
            $display("FAIL reset_mid_exec: got v=%b id=%0d y=%h z=%b rdy=%b want all 0", rsp_valid, rsp_id, rsp_y, rsp_zero, req_ready);
         else n_pass++;
         repeat (2) @(negedge clk);
         n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_no_rsp: got %b want 0", rsp_valid); else n_pass++;
         req_valid = '0;
         rst_n = 1'b1;
         @(posedge clk); #1;
         req_valid = (run == 0) ? 4'b0010 : 4'b1010;
         do_grant(1'b0, g, at, exp);
         n_checks++; if (g !== 1) $display("FAIL reset_post_grant: got %0d want 1", g); else n_pass++;
         req_valid = '0;
         wait_rsp(lat);
         n_checks++; if (rsp_id !== 2'd1) $display("FAIL reset_post_id: got %0d want 1", rsp_id); else n_pass++;
         consume();
      end
   endtask

   task automatic test_ops();
      logic [7:0] exp_y [4] = '{8'h05, 8'hAF, 8'hAA, 8'h5A};
      int g, at, exp, lat;
      for (int op = 0; op < 4; op++) begin
         set_req(2, 2'(op), 8'hA5, 8'h0F);
         do_grant(1'b0, g, at, exp);
         n_checks++; if (g !== 2) $display("FAIL op%0d_grant: got %0d want 2", op, g); else n_pass++;
         wait_rsp(lat);
         n_checks++; if (lat !== 2) $display("FAIL op%0d_latency: got %0d want 2", op, lat); else n_pass++;
         n_checks++; if ({rsp_y, rsp_id, rsp_zero} !== {exp_y[op], 2'd2, 1'b0})
            $display("FAIL op%0d_result: got y=%h id=%0d z=%b want y=%h id=2 z=0", op, rsp_y, rsp_id, rsp_zero, exp_y[op]);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_zero();
      int g, at, exp, lat;
      set_req(3, 2'd2, 8'h77, 8'h77);
      do_grant(1'b0, g, at, exp);
      n_checks++; if (g !== 3) $display("FAIL zero_grant: got %0d want 3", g); else n_pass++;
      wait_rsp(lat);
      n_checks++; if ({rsp_y, rsp_zero, rsp_id} !== {8'h00, 1'b1, 2'd3})
         $display("FAIL zero_flag: got y=%h z=%b id=%0d want y=00 z=1 id=3", rsp_y, rsp_zero, rsp_id);
      else n_pass++;
      consume();
   endtask

   task automatic test_round_robin();
      int g, at, exp, prev_at;
      int mh0 = multi_hot;
      prev_at = -1;
      for (int i = 0; i < NREQ; i++) set_req(i, 2'($urandom), 8'($urandom), 8'($urandom));
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         do_grant(1'b1, g, at, exp);
         n_checks++; if (g !== k % NREQ) $display("FAIL rr_order%0d: got %0d want %0d", k, g, k % NREQ); else n_pass++;
         if (k > 0) begin
            n_checks++; if (at - prev_at !== 3) $display("FAIL rr_interval%0d: got %0d want 3", k, at - prev_at); else n_pass++;
         end
         prev_at = at;
      end
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      n_checks++; if (multi_hot !== mh0) $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", multi_hot - mh0); else n_pass++;
   endtask

   task automatic test_back_pressure();
      int g, at, exp, lat, bad;
      logic [7:0] y0;
      logic [IDW-1:0] id0;
      bad = 0;
      set_req(1, 2'd1, 8'h5A, 8'h81);
      do_grant(1'b0, g, at, exp);
      n_checks++; if (g !== exp) $display("FAIL bp_grant: got %0d want %0d", g, exp); else n_pass++;
      wait_rsp(lat);
      y0 = rsp_y;
      id0 = rsp_id;
      n_checks++; if ({y0, id0} !== {8'hDB, 2'd1}) $display("FAIL bp_result: got y=%h id=%0d want y=db id=1", y0, id0); else n_pass++;
      set_req(0, 2'd0, 8'hFF, 8'h0F);
      set_req(3, 2'd3, 8'h0F, 8'h00);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_y !== y0 || rsp_id !== id0 || req_ready !== '0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk); #1;
      exp = model_winner(req_valid, model_ptr);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", rsp_valid); else n_pass++;
      n_checks++; if (req_ready !== 4'(1 << exp)) $display("FAIL bp_next_grant: got %b want %b", req_ready, 4'(1 << exp)); else n_pass++;
      @(posedge clk); #1;
      req_valid[exp] = 1'b0;
      model_ptr = (exp + 1) % NREQ;
      wait_rsp(lat);
      n_checks++; if ({lat, rsp_id, rsp_y} !== {32'd2, 2'd3, 8'hF0})
         $display("FAIL bp_next_rsp: got lat=%0d id=%0d y=%h want lat=2 id=3 y=f0", lat, rsp_id, rsp_y);
      else n_pass++;
      consume();
      req_valid = '0;
   endtask

   task automatic test_wrap();
      int g, at, exp, lat;
      set_req(2, 2'd0, 8'h11, 8'h11);
      do_grant(1'b0, g, at, exp);
      wait_rsp(lat);
      consume();
      set_req(3, 2'd1, 8'h10, 8'h01);
      set_req(1, 2'd3, 8'hC3, 8'hFF);
      do_grant(1'b0, g, at, exp);
      n_checks++; if (g !== 3) $display("FAIL wrap_first: got %0d want 3", g); else n_pass++;
      wait_rsp(lat);
      n_checks++; if (rsp_y !== 8'h11) $display("FAIL wrap_first_y: got %h want 11", rsp_y); else n_pass++;
      consume();
      do_grant(1'b0, g, at, exp);
      n_checks++; if (g !== 1) $display("FAIL wrap_second: got %0d want 1", g); else n_pass++;
      wait_rsp(lat);
      n_checks++; if ({rsp_y, rsp_id} !== {8'h3C, 2'd1}) $display("FAIL wrap_second_rsp: got y=%h id=%0d want y=3c id=1", rsp_y, rsp_id); else n_pass++;
      consume();
   endtask

   task automatic test_random();
      int g, at, exp, lat;
      logic [1:0] ops [NREQ];
      logic [7:0] as [NREQ];
      logic [7:0] bs [NREQ];
      logic [7:0] ey;
      for (int it = 0; it < 40; it++) begin
         req_valid = '0;
         for (int i = 0; i < NREQ; i++) begin
            ops[i] = 2'($urandom);
            as[i] = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
            bs[i] = (($urandom % 4) == 0) ? as[i] : 8'($urandom);
            req_op[2*i +: 2] = ops[i];
            req_a[WIDTH*i +: WIDTH] = as[i];
            req_b[WIDTH*i +: WIDTH] = bs[i];
         end
         req_valid = 4'($urandom_range(1, 15));
         do_grant(1'b0, g, at, exp);
         n_checks++; if (g !== exp) $display("FAIL rand%0d_grant: got %0d want %0d", it, g, exp); else n_pass++;
         req_valid = '0;
         wait_rsp(lat);
         ey = model_op(ops[exp], as[exp], bs[exp]);
         n_checks++; if ({lat, rsp_id, rsp_y, rsp_zero} !== {32'd2, 2'(exp), ey, (ey == 8'h00)})
            $display("FAIL rand%0d_rsp: got lat=%0d id=%0d y=%h z=%b want lat=2 id=%0d y=%h z=%b",
                     it, lat, rsp_id, rsp_y, rsp_zero, exp, ey, (ey == 8'h00));
         else n_pass++;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         consume();
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_zero();
      test_round_robin();
      test_back_pressure();
      test_wrap();
      test_random();
      n_checks++; if (multi_hot !== 0) $display("FAIL onehot_overall: got %0d multi-hot cycles want 0", multi_hot); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
